// File: rtl/countdown_timer_ctrl_if.sv
// countdown_timer_ctrl_if
//   Bundles the key/tick inputs and the display/status outputs of the
//   countdown timer core.
//   master : debouncers / prescaler / display side (drives keys and tick)
//   slave  : countdown_timer_ctrl
//   Signals:
//     ce_1hz     1-cycle-per-second clock enable
//     key_min    increment-minutes pulse
//     key_sec    increment-seconds pulse
//     key_start  start / pause / resume / acknowledge pulse
//     key_clr    clear pulse
//     min_tens, min_ones, sec_tens, sec_ones  current time, BCD
//     running    high in RUN
//     done       high in DONE
//     alarm      one-cycle pulse when DONE is entered
interface countdown_timer_ctrl_if;
    logic       ce_1hz;
    logic       key_min;
    logic       key_sec;
    logic       key_start;
    logic       key_clr;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic       alarm;

    modport master (
        output ce_1hz, key_min, key_sec, key_start, key_clr,
        input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
    );

    modport slave (
        input  ce_1hz, key_min, key_sec, key_start, key_clr,
        output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
//   BCD mm:ss countdown core. Keys set a preset in IDLE, KEY_START runs,
//   pauses and resumes the count, CE_1HZ decrements it, and reaching 00:00
//   raises DONE with a one-cycle ALARM.
//   Ports:
//     i_clk   system clock, rising edge
//     i_clr   asynchronous active-high reset
//     if_bus  key/tick inputs and time/status outputs (slave modport)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | time editable with KEY_MIN / KEY_SEC, waiting for start
//   ST_RUN   | counting down one second per CE_1HZ
//   ST_PAUSE | time frozen, KEY_START resumes, KEY_CLR abandons
//   ST_DONE  | reached 00:00, waiting for acknowledge or clear
module countdown_timer_ctrl (
    input  logic                   i_clk,
    input  logic                   i_clr,
    countdown_timer_ctrl_if.slave  if_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
    logic [3:0] r_pre_min_t, r_pre_min_o, r_pre_sec_t, r_pre_sec_o;
    logic       r_running;
    logic       r_done;
    logic       r_alarm;

    logic [3:0] w_inc_min_t, w_inc_min_o, w_inc_sec_t, w_inc_sec_o;
    logic [3:0] w_dec_min_t, w_dec_min_o, w_dec_sec_t, w_dec_sec_o;
    logic       w_time_zero;
    logic       w_dec_zero;

    // BCD increment with wrap (minutes 99->00, seconds 59->00, no carry)
    // and BCD decrement by one second with borrow from minutes.
    always_comb begin
        w_inc_min_t = r_min_t;
        w_inc_min_o = r_min_o + 4'd1;
        if (r_min_o == 4'd9) begin
            w_inc_min_o = 4'd0;
            w_inc_min_t = (r_min_t == 4'd9) ? 4'd0 : r_min_t + 4'd1;
        end

        w_inc_sec_t = r_sec_t;
        w_inc_sec_o = r_sec_o + 4'd1;
        if (r_sec_o == 4'd9) begin
            w_inc_sec_o = 4'd0;
            w_inc_sec_t = (r_sec_t == 4'd5) ? 4'd0 : r_sec_t + 4'd1;
        end

        w_dec_min_t = r_min_t;
        w_dec_min_o = r_min_o;
        w_dec_sec_t = r_sec_t;
        w_dec_sec_o = r_sec_o;
        if (r_sec_o != 4'd0) begin
            w_dec_sec_o = r_sec_o - 4'd1;
        end else begin
            w_dec_sec_o = 4'd9;
            if (r_sec_t != 4'd0) begin
                w_dec_sec_t = r_sec_t - 4'd1;
            end else begin
                // Only reached with minutes > 0: RUN never holds 00:00.
                w_dec_sec_t = 4'd5;
                if (r_min_o != 4'd0) begin
                    w_dec_min_o = r_min_o - 4'd1;
                end else begin
                    w_dec_min_o = 4'd9;
                    w_dec_min_t = r_min_t - 4'd1;
                end
            end
        end
    end

    assign w_time_zero = (r_min_t == 4'd0) && (r_min_o == 4'd0) &&
                         (r_sec_t == 4'd0) && (r_sec_o == 4'd0);
    assign w_dec_zero  = (w_dec_min_t == 4'd0) && (w_dec_min_o == 4'd0) &&
                         (w_dec_sec_t == 4'd0) && (w_dec_sec_o == 4'd0);

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state     <= ST_IDLE;
            r_min_t     <= 4'd0;
            r_min_o     <= 4'd0;
            r_sec_t     <= 4'd0;
            r_sec_o     <= 4'd0;
            r_pre_min_t <= 4'd0;
            r_pre_min_o <= 4'd0;
            r_pre_sec_t <= 4'd0;
            r_pre_sec_o <= 4'd0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_alarm <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_bus.key_clr) begin
                        r_min_t <= 4'd0;
                        r_min_o <= 4'd0;
                        r_sec_t <= 4'd0;
                        r_sec_o <= 4'd0;
                    end else if (if_bus.key_start) begin
                        // A start press consumes the cycle even when 00:00
                        // makes it a no-op.
                        if (!w_time_zero) begin
                            r_pre_min_t <= r_min_t;
                            r_pre_min_o <= r_min_o;
                            r_pre_sec_t <= r_sec_t;
                            r_pre_sec_o <= r_sec_o;
                            r_state     <= ST_RUN;
                            r_running   <= 1'b1;
                        end
                    end else begin
                        if (if_bus.key_min) begin
                            r_min_t <= w_inc_min_t;
                            r_min_o <= w_inc_min_o;
                        end
                        if (if_bus.key_sec) begin
                            r_sec_t <= w_inc_sec_t;
                            r_sec_o <= w_inc_sec_o;
                        end
                    end
                end
                ST_RUN: begin
                    if (if_bus.key_start) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (if_bus.ce_1hz) begin
                        r_min_t <= w_dec_min_t;
                        r_min_o <= w_dec_min_o;
                        r_sec_t <= w_dec_sec_t;
                        r_sec_o <= w_dec_sec_o;
                        if (w_dec_zero) begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_alarm   <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (if_bus.key_clr) begin
                        r_min_t <= 4'd0;
                        r_min_o <= 4'd0;
                        r_sec_t <= 4'd0;
                        r_sec_o <= 4'd0;
                        r_state <= ST_IDLE;
                    end else if (if_bus.key_start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (if_bus.key_clr) begin
                        r_min_t <= 4'd0;
                        r_min_o <= 4'd0;
                        r_sec_t <= 4'd0;
                        r_sec_o <= 4'd0;
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end else if (if_bus.key_start) begin
                        r_min_t <= r_pre_min_t;
                        r_min_o <= r_pre_min_o;
                        r_sec_t <= r_pre_sec_t;
                        r_sec_o <= r_pre_sec_o;
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign if_bus.min_tens = r_min_t;
    assign if_bus.min_ones = r_min_o;
    assign if_bus.sec_tens = r_sec_t;
    assign if_bus.sec_ones = r_sec_o;
    assign if_bus.running  = r_running;
    assign if_bus.done     = r_done;
    assign if_bus.alarm    = r_alarm;

endmodule
